// File: rtl/cond_sel_seq.sv
// N-channel registered multiplexer with manual select and automatic scan.
// Optional: define DEFAULT_ON_INVALID_EN to load DEFAULT_VAL on invalid select.
module cond_sel_seq #(
  parameter int               WIDTH       = 2,
  parameter int               SEL_W       = 2,
  parameter int               NUM_CH      = 3,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel_in,
  input  logic                    sel_vld,
  input  logic [NUM_CH*WIDTH-1:0] din,
  output logic [WIDTH-1:0]        dout,
  output logic                    dout_vld,
  output logic [SEL_W-1:0]        sel_cur,
  output logic                    hold_flag,
  output logic                    scan_done
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLD
  } state_t;

  localparam int CH_SLOTS = 2 ** SEL_W;
  localparam logic [SEL_W:0] NCH  = (SEL_W + 1)'(NUM_CH);
  localparam logic [SEL_W:0] LAST = (SEL_W + 1)'(NUM_CH - 1);

  state_t           state;
  logic [SEL_W-1:0] cnt;
  logic [WIDTH-1:0] ch [CH_SLOTS];
  logic             sel_ok;

  // Pad to a full power-of-two table so any select index is in bounds.
  for (genvar k = 0; k < CH_SLOTS; k++) begin : g_ch
    if (k < NUM_CH) begin : g_live
      assign ch[k] = din[k*WIDTH +: WIDTH];
    end else begin : g_pad
      assign ch[k] = '0;
    end
  end

  assign sel_ok = {1'b0, sel_in} < NCH;

`ifndef DEFAULT_ON_INVALID_EN
  logic unused_default;
  assign unused_default = ^DEFAULT_VAL;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      dout      <= '0;
      dout_vld  <= 1'b0;
      sel_cur   <= '0;
      hold_flag <= 1'b0;
      scan_done <= 1'b0;
    end else begin
      dout_vld  <= 1'b0;
      scan_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (en && mode) begin
            state <= SCAN;
            cnt   <= '0;
          end else if (en && sel_vld) begin
            if (sel_ok) begin
              dout      <= ch[sel_in];
              sel_cur   <= sel_in;
              dout_vld  <= 1'b1;
              hold_flag <= 1'b0;
            end else begin
              hold_flag <= 1'b1;
`ifdef DEFAULT_ON_INVALID_EN
              dout      <= DEFAULT_VAL;
              sel_cur   <= sel_in;
`endif
            end
          end
        end
        SCAN: begin
          if (!mode) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (!en) begin
            state <= HOLD;
          end else begin
            dout      <= ch[cnt];
            sel_cur   <= cnt;
            dout_vld  <= 1'b1;
            hold_flag <= 1'b0;
            if ({1'b0, cnt} == LAST) begin
              cnt       <= '0;
              scan_done <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (!mode) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (en) begin
            state <= SCAN;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cond_sel_seq.sv
// Directed bench for cond_sel_seq: manual select, invalid select,
// auto scan, pause/resume, mode abort and asynchronous reset.
module tb_cond_sel_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic [1:0] sel_in;
  logic       sel_vld;
  logic [5:0] din;
  logic [1:0] dout;
  logic       dout_vld;
  logic [1:0] sel_cur;
  logic       hold_flag;
  logic       scan_done;

  int n_chk  = 0;
  int n_pass = 0;

  cond_sel_seq #(
    .WIDTH      (2),
    .SEL_W      (2),
    .NUM_CH     (3),
    .DEFAULT_VAL(2'd0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .mode     (mode),
    .sel_in   (sel_in),
    .sel_vld  (sel_vld),
    .din      (din),
    .dout     (dout),
    .dout_vld (dout_vld),
    .sel_cur  (sel_cur),
    .hold_flag(hold_flag),
    .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic chk_all(input string tag, input logic [1:0] d,
                         input logic v, input logic [1:0] s,
                         input logic h, input logic sd);
    check({tag, ".dout"}, 32'(dout), 32'(d));
    check({tag, ".vld"}, 32'(dout_vld), 32'(v));
    check({tag, ".sel"}, 32'(sel_cur), 32'(s));
    check({tag, ".hold"}, 32'(hold_flag), 32'(h));
    check({tag, ".done"}, 32'(scan_done), 32'(sd));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_d  [7] = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd1};
  logic [1:0] exp_s  [7] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
  logic       exp_sd [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    rst_n   = 1'b0;
    en      = 1'b0;
    mode    = 1'b0;
    sel_in  = 2'd0;
    sel_vld = 1'b0;
    din     = {2'd3, 2'd2, 2'd1};
    step();
    chk_all("reset", 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();

    // manual sweep
    en = 1'b1;
    sel_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sel_in = 2'(i);
      step();
      chk_all($sformatf("man%0d", i), 2'(i + 1), 1'b1, 2'(i), 1'b0, 1'b0);
    end

    // invalid select
    sel_in = 2'd3;
    step();
`ifdef DEFAULT_ON_INVALID_EN
    chk_all("inval", 2'd0, 1'b0, 2'd3, 1'b1, 1'b0);
`else
    chk_all("inval", 2'd3, 1'b0, 2'd2, 1'b1, 1'b0);
`endif
    sel_vld = 1'b0;
    sel_in = 2'd1;
    step();
    check("novld.vld", 32'(dout_vld), 32'd0);
    check("novld.hold", 32'(hold_flag), 32'd1);

    // auto scan: first edge only enters SCAN
    mode = 1'b1;
    step();
    check("scan_entry.vld", 32'(dout_vld), 32'd0);
    for (int i = 0; i < 7; i++) begin
      step();
      chk_all($sformatf("scan%0d", i), exp_d[i], 1'b1, exp_s[i],
              1'b0, exp_sd[i]);
    end

    // pause and resume
    step();
    chk_all("pre_pause", 2'd2, 1'b1, 2'd1, 1'b0, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all($sformatf("pause%0d", i), 2'd2, 1'b0, 2'd1, 1'b0, 1'b0);
    end
    en = 1'b1;
    step();
    check("resume_entry.vld", 32'(dout_vld), 32'd0);
    step();
    chk_all("resume", 2'd3, 1'b1, 2'd2, 1'b0, 1'b1);

    // mode abort
    step();
    step();
    chk_all("pre_abort", 2'd2, 1'b1, 2'd1, 1'b0, 1'b0);
    mode = 1'b0;
    step();
    chk_all("abort", 2'd2, 1'b0, 2'd1, 1'b0, 1'b0);
    mode = 1'b1;
    step();
    check("rescan_entry.vld", 32'(dout_vld), 32'd0);
    step();
    chk_all("rescan", 2'd1, 1'b1, 2'd0, 1'b0, 1'b0);
    step();
    step();
    chk_all("prerst", 2'd3, 1'b1, 2'd2, 1'b0, 1'b1);

    // asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    #3;
    rst_n = 1'b1;
    mode = 1'b0;
    en = 1'b0;
    step();
    chk_all("post_rst", 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    en = 1'b1;
    sel_vld = 1'b1;
    sel_in = 2'd1;
    step();
    chk_all("post_rst_man", 2'd2, 1'b1, 2'd1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cond_sel_seq.md
Name: cond_sel_seq

Overview:
- Parametrised, registered successor to the 2-bit combinational selector: an N-channel, W-bit registered multiplexer.
- Two modes: manual select and automatic channel scan.
- Out-of-range select holds the last value in a flop, giving latch-style behaviour without an inferred latch.
- Feeds downstream checkers and display logic that need a stable, one-cycle-latency selected value.

Parameters:
- WIDTH, 2: data width per channel and of dout.
- SEL_W, 2: select width.
- NUM_CH, 3: number of valid channels; legal range 1 <= NUM_CH <= 2**SEL_W.
- DEFAULT_VAL, 0: WIDTH-bit value driven on invalid select when DEFAULT_ON_INVALID_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  block enable.
- mode  in  1  0 = manual select, 1 = auto scan.
- sel_in  in  SEL_W  manual channel select.
- sel_vld  in  1  sel_in qualifier in manual mode.
- din  in  NUM_CH*WIDTH  flat channel bus; channel k occupies din[k*WIDTH +: WIDTH].
- dout  out  WIDTH  registered selected data.
- dout_vld  out  1  dout updated this cycle from a valid channel.
- sel_cur  out  SEL_W  channel index that produced dout.
- hold_flag  out  1  last request was out of range; dout not refreshed.
- scan_done  out  1  one-cycle pulse when the scan wraps.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_n=0 all outputs are 0: dout=0, dout_vld=0, sel_cur=0, hold_flag=0, scan_done=0. FSM state is IDLE and the scan counter cnt is 0.
- Latency: all outputs are registered. A request sampled at edge N appears after edge N.
- FSM states: IDLE, SCAN, HOLD.
  - IDLE -> SCAN when en=1 and mode=1. cnt starts at 0.
  - SCAN -> HOLD when en=0. cnt is frozen.
  - HOLD -> SCAN when en=1 and mode=1. Scan resumes from the frozen cnt.
  - SCAN or HOLD -> IDLE when mode=0. cnt is cleared to 0 on that edge.
- Manual mode (state IDLE, en=1, sel_vld=1):
  - sel_in < NUM_CH: dout <= din[sel_in], sel_cur <= sel_in, dout_vld <= 1, hold_flag <= 0.
  - sel_in >= NUM_CH: dout and sel_cur keep their values, dout_vld <= 0, hold_flag <= 1.
  - sel_vld=0 or en=0: dout, sel_cur and hold_flag keep their values; dout_vld <= 0.
- SCAN, each cycle:
  - dout <= din[cnt], sel_cur <= cnt, dout_vld <= 1, hold_flag <= 0.
  - If cnt == NUM_CH-1: cnt <= 0 and scan_done <= 1. Otherwise cnt <= cnt+1 and scan_done <= 0.
- HOLD: outputs keep their values; dout_vld <= 0, scan_done <= 0.
- Simultaneous events:
  - mode=0 and en=0 in the same cycle while in SCAN: go to IDLE.
  - sel_vld is ignored outside IDLE.
- NUM_CH=1: scan_done pulses every SCAN cycle.
- Index arithmetic: cnt is SEL_W bits. Compare against NUM_CH at SEL_W+1 bits so the comparison is correct when NUM_CH = 2**SEL_W.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: DEFAULT_ON_INVALID_EN.
- Defined: manual out-of-range select loads dout <= DEFAULT_VAL and sel_cur <= sel_in. hold_flag is still set to 1 and dout_vld to 0.
- Not defined: dout holds its last value (hold behaviour described above).
- SCAN behaviour is identical in both builds.

Test Plan:
All cases use WIDTH=2, SEL_W=2, NUM_CH=3, ch0=1, ch1=2, ch2=3.
1. Reset: assert rst_n=0 mid-operation with no clock edge -> all outputs 0 immediately. After release, IDLE with dout=0.
2. Manual sweep: mode=0, en=1, sel_vld=1, sel_in = 0,1,2 on successive edges -> dout = 1,2,3 one cycle later, dout_vld=1, sel_cur matches sel_in.
3. Invalid select:
   - Without macro: after sel_in=2, apply sel_in=3 -> dout stays 3, hold_flag=1, dout_vld=0.
   - With DEFAULT_ON_INVALID_EN and DEFAULT_VAL=0: same stimulus -> dout=0, sel_cur=3, hold_flag=1.
4. Auto scan: mode=1, en=1 for 7 cycles -> dout = 1,2,3,1,2,3,1 and scan_done high on the 3rd and 6th output cycles.
5. Pause and resume: en=0 after dout=2 for 3 cycles -> dout stays 2, dout_vld=0. Re-enable -> next dout=3, no restart from 0.
6. Mode abort: mode=0 while dout=2 in SCAN -> state IDLE, cnt=0. mode=1 again -> next dout=1.
